// File: rtl/dac_setpoint_ctrl.sv
// dac_setpoint_ctrl: button-driven DAC setpoint with a saturating up/down code,
// a coarse/fine step mode, and a request/ack write FSM with a post-write holdoff.
// The build macro DAC_AUTO_COMMIT_EN makes every cycle where code changes act as a commit.
`timescale 1ns/1ps
module dac_setpoint_ctrl #(
    parameter int DATA_W      = 8,
    parameter int STEP_COARSE = 16,
    parameter int HOLDOFF     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn_trig,
    input  logic              wr_ack,
    output logic              wr_req,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] code,
    output logic              coarse,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // The counter counts down from HOLDOFF-1 to 0, so HOLD spans HOLDOFF cycles.
    localparam int               CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [DATA_W:0] CODE_MAX = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W:0] STEP_C   = (DATA_W + 1)'(STEP_COARSE);
    localparam logic [DATA_W:0] STEP_F   = (DATA_W + 1)'(1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              pending;
    logic              up;
    logic              down;
    logic              toggle;
    logic              commit;
    logic [DATA_W:0]   step;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] next_code;

    assign up     = btn_trig[0];
    assign down   = btn_trig[1];
    assign toggle = btn_trig[2];

    // Saturating next setpoint, computed one bit wider so carry and borrow are visible.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        step      = coarse ? STEP_C : STEP_F;
        sum       = {1'b0, code} + step;
        diff      = {1'b0, code} - step;
        next_code = code;
        if (up && !down) begin
            next_code = (sum > CODE_MAX) ? CODE_MAX[DATA_W-1:0] : sum[DATA_W-1:0];
        end else if (down && !up) begin
            next_code = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
        end
    end

`ifdef DAC_AUTO_COMMIT_EN
    assign commit = btn_trig[3] | (next_code != code);
`else
    assign commit = btn_trig[3];
`endif

    // Setpoint and step mode follow the buttons in every FSM state; toggle uses the old mode this cycle.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            code   <= '0;
            coarse <= 1'b0;
        end else begin
            code <= next_code;
            if (toggle) begin
                coarse <= ~coarse;
            end
        end
    end

    // Write FSM: IDLE waits for a commit, REQ holds the request until ack, HOLD enforces the idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            cnt     <= '0;
            wr_req  <= 1'b0;
            wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit) begin
                        state   <= S_REQ;
                        wr_req  <= 1'b1;
                        wr_data <= next_code;
                    end
                end
                S_REQ: begin
                    if (commit) begin
                        pending <= 1'b1;
                    end
                    if (wr_ack) begin
                        state  <= S_HOLD;
                        wr_req <= 1'b0;
                        cnt    <= CNT_LOAD;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        if (pending) begin
                            // A commit landing on this last cycle stays queued for the next round.
                            state   <= S_REQ;
                            wr_req  <= 1'b1;
                            wr_data <= code;
                            pending <= commit;
                        end else if (commit) begin
                            state   <= S_REQ;
                            wr_req  <= 1'b1;
                            wr_data <= next_code;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (commit) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dac_setpoint_ctrl.sv
// tb_dac_setpoint_ctrl: directed scenarios plus randomized traffic against a cycle-level
// behavioural model of dac_setpoint_ctrl. Honours DAC_AUTO_COMMIT_EN when defined.
`timescale 1ns/1ps
module tb_dac_setpoint_ctrl;

    localparam int DATA_W      = 8;
    localparam int STEP_COARSE = 16;
    localparam int HOLDOFF     = 1000;
    localparam int CODE_MAX    = (1 << DATA_W) - 1;
`ifdef DAC_AUTO_COMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        btn_trig;
    logic              wr_ack;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] code;
    logic              coarse;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: integer setpoint, request flag, remaining holdoff cycles, pending flag.
    int m_code;
    bit m_coarse;
    bit m_req;
    int m_data;
    int m_hold_left;
    bit m_pending;

    always #5 clk = ~clk;

    dac_setpoint_ctrl #(
        .DATA_W     (DATA_W),
        .STEP_COARSE(STEP_COARSE),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_trig(btn_trig),
        .wr_ack  (wr_ack),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .code    (code),
        .coarse  (coarse),
        .busy    (busy)
    );

    task automatic model_tick(input logic [3:0] t, input logic a, input logic r);
        int  nc;
        int  stp;
        bit  cm;
        if (r) begin
            m_code = 0; m_coarse = 0; m_req = 0; m_data = 0; m_hold_left = 0; m_pending = 0;
        end else begin
            stp = m_coarse ? STEP_COARSE : 1;
            nc  = m_code;
            if (t[0] && !t[1])      nc = (m_code + stp > CODE_MAX) ? CODE_MAX : m_code + stp;
            else if (t[1] && !t[0]) nc = (m_code - stp < 0) ? 0 : m_code - stp;
            cm = t[3] || (AUTO && nc != m_code);
            if (m_req) begin
                if (cm) m_pending = 1;
                if (a) begin m_req = 0; m_hold_left = HOLDOFF; end
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    if (m_pending)  begin m_req = 1; m_data = m_code; m_pending = cm; end
                    else if (cm)    begin m_req = 1; m_data = nc; end
                end else if (cm) begin
                    m_pending = 1;
                end
            end else if (cm) begin
                m_req = 1; m_data = nc;
            end
            m_code = nc;
            if (t[2]) m_coarse = !m_coarse;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle for sampling.
    task automatic step(input logic [3:0] t, input logic a = 1'b0, input logic r = 1'b0);
        btn_trig = t; wr_ack = a; rst = r;
        @(posedge clk);
        model_tick(t, a, r);
        #1;
        btn_trig = '0; wr_ack = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        vectors++; if (code !== '0)   begin miscompares++; $display("FAIL reset_code: got %0d want 0", code); end
        vectors++; if (coarse !== 0)  begin miscompares++; $display("FAIL reset_coarse: got %b want 0", coarse); end
        vectors++; if (wr_req !== 0)  begin miscompares++; $display("FAIL reset_wr_req: got %b want 0", wr_req); end
        vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
        vectors++; if (busy !== 0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_handshake();
        int n;
        step(4'b0000, 1'b0, 1'b1);
        repeat (3) step(4'b0001);
        vectors++; if (code !== DATA_W'(3)) begin miscompares++; $display("FAIL hs_code: got %0d want 3", code); end
        step(4'b1000);
        vectors++; if (wr_req !== 1) begin miscompares++; $display("FAIL hs_req_c1: got %b want 1", wr_req); end
        vectors++; if (wr_data !== DATA_W'(3)) begin miscompares++; $display("FAIL hs_data: got %0d want 3", wr_data); end
        step(4'b0000);
        vectors++; if (wr_req !== 1) begin miscompares++; $display("FAIL hs_req_c2: got %b want 1", wr_req); end
        step(4'b0000);
        vectors++; if (wr_req !== 1) begin miscompares++; $display("FAIL hs_req_c3: got %b want 1", wr_req); end
        step(4'b0000, 1'b1);
        vectors++; if (wr_req !== 0) begin miscompares++; $display("FAIL hs_req_after_ack: got %b want 0", wr_req); end
        vectors++; if (busy !== 1)   begin miscompares++; $display("FAIL hs_busy_hold: got %b want 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < HOLDOFF + 100) begin step(4'b0000); n++; end
        vectors++; if (n != HOLDOFF) begin miscompares++; $display("FAIL hs_holdoff_len: got %0d cycles want %0d", n, HOLDOFF); end
    endtask

    task automatic test_saturation();
        int want;
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100);
        vectors++; if (coarse !== 1) begin miscompares++; $display("FAIL sat_coarse: got %b want 1", coarse); end
        for (int i = 1; i <= 16; i++) begin
            step(4'b0001);
            want = (i * STEP_COARSE > CODE_MAX) ? CODE_MAX : i * STEP_COARSE;
            vectors++; if (code !== DATA_W'(want)) begin miscompares++; $display("FAIL sat_up_%0d: got %0d want %0d", i, code, want); end
        end
        step(4'b0010);
        vectors++; if (code !== DATA_W'(239)) begin miscompares++; $display("FAIL sat_down: got %0d want 239", code); end
    endtask

    task automatic test_updown();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010);
        vectors++; if (code !== '0) begin miscompares++; $display("FAIL floor_zero: got %0d want 0", code); end
        repeat (5) step(4'b0001);
        step(4'b0011);
        vectors++; if (code !== DATA_W'(5)) begin miscompares++; $display("FAIL up_and_down: got %0d want 5", code); end
        step(4'b0101);
        vectors++; if (code !== DATA_W'(6)) begin miscompares++; $display("FAIL toggle_same_cycle: got %0d want 6", code); end
    endtask

    task automatic test_pending();
        int n;
        int extra;
        step(4'b0000, 1'b0, 1'b1);
        repeat (4) step(4'b0001);
        step(4'b1000);
        vectors++; if (wr_data !== DATA_W'(4)) begin miscompares++; $display("FAIL pend_first_data: got %0d want 4", wr_data); end
        step(4'b0000, 1'b1);
        step(4'b0001);
        step(4'b0001);
        step(4'b1000);
        step(4'b1000);
        vectors++; if (code !== DATA_W'(6)) begin miscompares++; $display("FAIL pend_code: got %0d want 6", code); end
        n = 4;
        while (wr_req !== 1'b1 && n < HOLDOFF + 100) begin step(4'b0000); n++; end
        vectors++; if (n != HOLDOFF) begin miscompares++; $display("FAIL pend_req_cycle: got %0d want %0d", n, HOLDOFF); end
        vectors++; if (wr_data !== DATA_W'(6)) begin miscompares++; $display("FAIL pend_data: got %0d want 6", wr_data); end
        step(4'b0000, 1'b1);
        n = 0; extra = 0;
        while (busy === 1'b1 && n < HOLDOFF + 100) begin
            step(4'b0000);
            if (wr_req === 1'b1) extra++;
            n++;
        end
        vectors++; if (extra != 0 || busy !== 0) begin miscompares++; $display("FAIL pend_single: got %0d extra req busy=%b want 0 and 0", extra, busy); end
    endtask

    task automatic test_reset_mid_req();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100);
        step(4'b0001);
        step(4'b1000);
        vectors++; if (wr_req !== 1) begin miscompares++; $display("FAIL rmid_req: got %b want 1", wr_req); end
        step(4'b0000, 1'b0, 1'b1);
        vectors++; if (wr_req !== 0)   begin miscompares++; $display("FAIL rmid_req_drop: got %b want 0", wr_req); end
        vectors++; if (code !== '0)    begin miscompares++; $display("FAIL rmid_code: got %0d want 0", code); end
        vectors++; if (coarse !== 0)   begin miscompares++; $display("FAIL rmid_coarse: got %b want 0", coarse); end
        vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL rmid_data: got %0d want 0", wr_data); end
        step(4'b0000, 1'b1);
        vectors++; if (busy !== 0 || wr_req !== 0) begin miscompares++; $display("FAIL rmid_late_ack: got busy=%b req=%b want 0 0", busy, wr_req); end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin step(4'b0000, wr_req); n++; end
        vectors++; if (busy !== 0) begin miscompares++; $display("FAIL drain_timeout: got busy=%b want 0", busy); end
    endtask

    task automatic test_auto_commit();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001);
`ifdef DAC_AUTO_COMMIT_EN
        vectors++; if (wr_req !== 1) begin miscompares++; $display("FAIL auto_req: got %b want 1", wr_req); end
        vectors++; if (wr_data !== DATA_W'(1)) begin miscompares++; $display("FAIL auto_data: got %0d want 1", wr_data); end
        drain();
        step(4'b0100);
        repeat (16) step(4'b0001);
        drain();
        vectors++; if (code !== DATA_W'(CODE_MAX)) begin miscompares++; $display("FAIL auto_sat_code: got %0d want %0d", code, CODE_MAX); end
        step(4'b0001);
        vectors++; if (wr_req !== 0 || busy !== 0) begin miscompares++; $display("FAIL auto_sat_noreq: got req=%b busy=%b want 0 0", wr_req, busy); end
`else
        vectors++; if (wr_req !== 0 || busy !== 0) begin miscompares++; $display("FAIL noauto_noreq: got req=%b busy=%b want 0 0", wr_req, busy); end
        vectors++; if (code !== DATA_W'(1)) begin miscompares++; $display("FAIL noauto_code: got %0d want 1", code); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] t;
        logic       a;
        logic       r;
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            t[0] = ($urandom_range(0, 3) == 0);
            t[1] = ($urandom_range(0, 3) == 0);
            t[2] = ($urandom_range(0, 7) == 0);
            t[3] = ($urandom_range(0, 15) == 0);
            a    = ($urandom_range(0, 2) == 0);
            r    = ($urandom_range(0, 999) == 0);
            step(t, a, r);
            vectors++; if (code !== DATA_W'(m_code)) begin miscompares++; $display("FAIL rnd_code @%0d: got %0d want %0d", i, code, m_code); end
            vectors++; if (coarse !== m_coarse)      begin miscompares++; $display("FAIL rnd_coarse @%0d: got %b want %b", i, coarse, m_coarse); end
            vectors++; if (wr_req !== m_req)         begin miscompares++; $display("FAIL rnd_wr_req @%0d: got %b want %b", i, wr_req, m_req); end
            vectors++; if (wr_data !== DATA_W'(m_data)) begin miscompares++; $display("FAIL rnd_wr_data @%0d: got %0d want %0d", i, wr_data, m_data); end
            vectors++; if (busy !== (m_req || m_hold_left > 0)) begin miscompares++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, (m_req || m_hold_left > 0)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; btn_trig = '0; wr_ack = 1'b0;
        m_code = 0; m_coarse = 0; m_req = 0; m_data = 0; m_hold_left = 0; m_pending = 0;
        test_reset();
`ifndef DAC_AUTO_COMMIT_EN
        test_handshake();
        test_pending();
`endif
        test_saturation();
        test_updown();
        test_reset_mid_req();
        test_auto_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
